// File: rtl/handshake_master.sv
`default_nettype none
// ============================================================================
// Module   : handshake_master
// Purpose  : FIFO-buffered valid/ready source with a transfer counter.
//            Define MASTER_TIMEOUT_EN for stall detection and retry.
// Revision : 1.0 - initial release
// ============================================================================
module handshake_master #(
    parameter int NUM     = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [NUM-1:0]  wr_data,
    output logic            full,
    input  logic            busy,
    input  logic            ready,
    output logic            valid,
    output logic [NUM-1:0]  data_out,
    output logic [15:0]     tx_count,
    output logic            err
);

    localparam int                c_ADDR_W    = $clog2(DEPTH);
    localparam logic [c_ADDR_W:0] c_DEPTH_CNT = (c_ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
`ifdef MASTER_TIMEOUT_EN
    localparam logic [1:0] c_ST_RETRY = 2'd2;
`endif

    logic [NUM-1:0]      r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [1:0]          r_state;
    logic                r_valid;
    logic [NUM-1:0]      r_data;
    logic [15:0]         r_tx_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_xfer;
    logic w_timeout;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_xfer  = (r_state == c_ST_SEND) && ready;
    // A new word leaves the FIFO either from idle or in the same edge a transfer completes
    assign w_pop   = ((r_state == c_ST_IDLE) || w_xfer) && !w_empty && !busy;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_tx_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_data  <= r_mem[r_rd_ptr];
                        r_valid <= 1'b1;
                        r_state <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (ready) begin
                        r_tx_count <= r_tx_count + 16'd1;
                        if (w_pop) begin
                            r_data <= r_mem[r_rd_ptr];
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_timeout) begin
`ifdef MASTER_TIMEOUT_EN
                        r_valid <= 1'b0;
                        r_state <= c_ST_RETRY;
`endif
                    end
                end
`ifdef MASTER_TIMEOUT_EN
                c_ST_RETRY: begin
                    r_valid <= 1'b1;
                    r_state <= c_ST_SEND;
                end
`endif
                default: begin
                    r_valid <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

`ifdef MASTER_TIMEOUT_EN
    localparam int                c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;

    // The edge that would bring the stall count to TIMEOUT is the timeout edge
    assign w_timeout = (r_state == c_ST_SEND) && !ready && (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state == c_ST_SEND) && !ready && !w_timeout) begin
                r_wait <= r_wait + 1'b1;
            end else begin
                r_wait <= '0;
            end
        end
    end

    assign err = r_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT;
    assign w_timeout        = 1'b0;
    assign err              = 1'b0;
`endif

    assign full     = w_full;
    assign valid    = r_valid;
    assign data_out = r_data;
    assign tx_count = r_tx_count;

endmodule
`default_nettype wire
